power_alu_seq: RTL and testbench

Parametrised, registered successor to the 8-bit combinational power ALU. Accepts one operation per cycle over a valid/ready handshake, registers the result with carry/zero/negative/overflow flags, and adds an optional multi-cycle shift-add multiplier. Sits between the operand/opcode source and the result consumer in the datapath. The opcode encoding of the earlier ALU is kept for codes 0000–1110.

---
 rtl/power_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_power_alu_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_alu_seq.sv
// Registered power ALU with valid/ready handshake on both sides and C/Z/N/V flags.
// Define POWER_ALU_MUL_EN to turn opcode 1111 into a WIDTH-cycle shift-add multiplier.
module power_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             err
);
    localparam logic [3:0] OP_INC  = 4'h0;
    localparam logic [3:0] OP_DEC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_TRAN = 4'h4;
    localparam logic [3:0] OP_ONES = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_XNOR = 4'hB;
    localparam logic [3:0] OP_GT   = 4'hC;
    localparam logic [3:0] OP_LT   = 4'hD;
    localparam logic [3:0] OP_EQ   = 4'hE;

    logic             accept;
    logic             busy;
    logic             mul_start;
    logic             mul_done;
    logic             single_load;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   add_res;
    logic [WIDTH:0]   sub_res;
    logic [WIDTH-1:0] nx_result;
    logic             nx_c;
    logic             nx_v;
    logic             nx_err;

    // INC/DEC share the adder/subtractor with a constant second operand
    always_comb begin
        opnd_b    = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
        add_res   = {1'b0, a} + {1'b0, opnd_b};
        sub_res   = {1'b0, a} - {1'b0, opnd_b};
        nx_result = '0;
        nx_c      = 1'b0;
        nx_v      = 1'b0;
        nx_err    = 1'b0;
        case (op)
            OP_INC, OP_ADD: begin
                nx_result = add_res[WIDTH-1:0];
                nx_c      = add_res[WIDTH];
                nx_v      = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DEC, OP_SUB: begin
                nx_result = sub_res[WIDTH-1:0];
                nx_c      = sub_res[WIDTH];
                nx_v      = (a[WIDTH-1] != opnd_b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_TRAN: nx_result = a;
            OP_ONES: nx_result = ~a;
            OP_AND:  nx_result = a & b;
            OP_NAND: nx_result = ~(a & b);
            OP_OR:   nx_result = a | b;
            OP_NOR:  nx_result = ~(a | b);
            OP_XOR:  nx_result = a ^ b;
            OP_XNOR: nx_result = ~(a ^ b);
            OP_GT:   nx_result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_LT:   nx_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_EQ:   nx_result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: nx_err    = 1'b1;
        endcase
    end

    assign in_ready = !busy && (!out_valid || out_ready) && !rst;
    assign accept   = in_valid && in_ready;

`ifdef POWER_ALU_MUL_EN
    // state  | meaning
    // S_IDLE | accepting operations; single-cycle ops complete here
    // S_MUL  | shift-add iterations, cnt = 0..WIDTH-1, input blocked
    localparam logic [3:0] OP_MUL = 4'hF;
    localparam int         CNT_W  = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH:0]   step_sum;

    assign busy        = (state == S_MUL);
    assign mul_start   = accept && (op == OP_MUL);
    assign mul_done    = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));
    assign step_sum    = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign mul_hi_next = step_sum[WIDTH:1];
    assign mul_lo_next = {step_sum[0], prod_lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mul_start) begin
                        state   <= S_MUL;
                        cnt     <= '0;
                        mcand   <= a;
                        prod_hi <= '0;
                        prod_lo <= b;
                    end
                end
                S_MUL: begin
                    prod_hi <= mul_hi_next;
                    prod_lo <= mul_lo_next;
                    if (mul_done) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign busy        = 1'b0;
    assign mul_start   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_hi_next = '0;
    assign mul_lo_next = '0;
`endif

    assign single_load = accept && !mul_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else if (single_load) begin
            out_valid <= 1'b1;
            result    <= nx_result;
            result_hi <= '0;
            flag_c    <= nx_c;
            flag_z    <= (nx_result == '0);
            flag_n    <= nx_result[WIDTH-1];
            flag_v    <= nx_v;
            err       <= nx_err;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_lo_next;
            result_hi <= mul_hi_next;
            flag_c    <= 1'b0;
            flag_z    <= ({mul_hi_next, mul_lo_next} == '0);
            flag_n    <= mul_hi_next[WIDTH-1];
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_power_alu_seq.sv
// Scoreboard bench for power_alu_seq at WIDTH=8; MUL scenarios follow POWER_ALU_MUL_EN.
module tb_power_alu_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       flag_c, flag_z, flag_n, flag_v, err;

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    bit   rand_bp = 1'b0;

    power_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t       e;
        int         s;
        int         sv;
        logic [7:0] yy;
        logic [15:0] p;
        e  = '0;
        yy = (o == 4'h0 || o == 4'h1) ? 8'h01 : y;
        case (o)
            4'h0, 4'h2: begin
                s     = int'(x) + int'(yy);
                sv    = int'($signed(x)) + int'($signed(yy));
                e.res = s[7:0];
                e.c   = (s > 255);
                e.v   = (sv > 127) || (sv < -128);
            end
            4'h1, 4'h3: begin
                s     = int'(x) - int'(yy);
                sv    = int'($signed(x)) - int'($signed(yy));
                e.res = s[7:0];
                e.c   = (yy > x);
                e.v   = (sv > 127) || (sv < -128);
            end
            4'h4: e.res = x;
            4'h5: e.res = ~x;
            4'h6: e.res = x & y;
            4'h7: e.res = ~(x & y);
            4'h8: e.res = x | y;
            4'h9: e.res = ~(x | y);
            4'hA: e.res = x ^ y;
            4'hB: e.res = ~(x ^ y);
            4'hC: e.res = (x > y) ? 8'd1 : 8'd0;
            4'hD: e.res = (x < y) ? 8'd1 : 8'd0;
            4'hE: e.res = (x == y) ? 8'd1 : 8'd0;
            default: begin
`ifdef POWER_ALU_MUL_EN
                p     = {8'h00, x} * {8'h00, y};
                e.res = p[7:0];
                e.hi  = p[15:8];
`else
                p     = '0;
                e.e   = 1'b1;
`endif
            end
        endcase
        if (o == 4'hF) begin
            e.z = ({e.hi, e.res} == 16'h0);
            e.n = e.hi[7];
        end else begin
            e.z = (e.res == 8'h00);
            e.n = e.res[7];
        end
        return e;
    endfunction

    // Drives one op and returns just after the accepting edge; waits counts stalled cycles
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, output int waits);
        op = o; a = x; b = y; in_valid = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 100) begin
                chk("accept_timeout", 32'(waits), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("result_hi", 32'(result_hi), 32'(e.hi));
                    chk("flags_czvne", {27'd0, flag_c, flag_z, flag_n, flag_v, err},
                        {27'd0, e.c, e.z, e.n, e.v, e.e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt_bad;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {result_hi, result, 3'd0, flag_c, flag_z, flag_n, flag_v, err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(4'h2, 8'hFF, 8'h01, w);
        @(negedge clk);
        chk("add_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(4'h3, 8'h80, 8'h01, w);
        send(4'hD, 8'h03, 8'h05, w);
`ifndef POWER_ALU_MUL_EN
        send(4'hF, 8'h12, 8'h34, w);
        @(negedge clk);
        chk("illegal_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Backpressure: result must hold and input must stall
        out_ready = 1'b0;
        send(4'h2, 8'h10, 8'h20, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {15'd0, out_valid, in_ready, result, flag_c, flag_z, flag_n, flag_v, err, 2'd0},
                {15'd0, 1'b1, 1'b0, 8'h30, 5'b00000, 2'd0});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'h0, 8'h7F, 8'h00, w);
        chk("stream_inc_wait", 32'(w), 32'd0);
        send(4'hA, 8'hA5, 8'h0F, w);
        chk("stream_xor_wait", 32'(w), 32'd0);
        send(4'hE, 8'h5A, 8'h5A, w);
        chk("stream_eq_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

`ifdef POWER_ALU_MUL_EN
        send(4'hF, 8'hFF, 8'hFF, w);
        a = 8'h00; b = 8'h00; op = 4'h2;
        cnt_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) cnt_bad++;
        end
        chk("mul_stall_cycles", 32'(cnt_bad), 32'd0);
        @(negedge clk);
        chk("mul_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        send(4'hF, 8'h0F, 8'h0F, w);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("mul_rst_outputs", {out_valid, result_hi, result, flag_z, flag_n}, 19'd0);
        chk("mul_rst_in_ready", 32'(in_ready), 32'd1);
        cnt_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) cnt_bad++;
        end
        chk("mul_rst_no_emit", 32'(cnt_bad), 32'd0);
        @(posedge clk);
        #1;
`endif

        // Reset while a result is held discards it
        out_ready = 1'b0;
        send(4'h6, 8'hF0, 8'h3C, w);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("held_rst_clear", {out_valid, result, result_hi}, 17'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), w);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
